wait_any_arbiter: RTL

Synthesizable equivalent of a procedural `wait(a || b || ...)` that sits beside the sequencing logic. An upstream controller arms it, and it blocks until any bit of a condition vector is high or an optional cycle timeout expires. It then reports which condition fired, using lowest-index priority and 1-based encoding with 0 meaning none, plus the elapsed wait time. Results are held until the consumer acknowledges them.

---
 rtl/wait_any_arbiter_if.sv | 28 ++
 rtl/wait_any_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/wait_any_arbiter_if.sv
// rtl/wait_any_arbiter_if.sv - handshake bundle between a sequencer and wait_any_arbiter
interface wait_any_arbiter_if #(
    parameter int N  = 4,
    parameter int TW = 16
);
    localparam int WW = $clog2(N + 1);

    logic          arm;
    logic [TW-1:0] timeout;
    logic          abort;
    logic [N-1:0]  cond;
    logic          busy;
    logic          done;
    logic          ack;
    logic [WW-1:0] which;
    logic          timed_out;
    logic [TW-1:0] wait_cycles;

    modport master (
        output arm, timeout, abort, cond, ack,
        input  busy, done, which, timed_out, wait_cycles
    );

    modport slave (
        input  arm, timeout, abort, cond, ack,
        output busy, done, which, timed_out, wait_cycles
    );
endinterface

// File: rtl/wait_any_arbiter.sv
// rtl/wait_any_arbiter.sv - armed wait on any condition bit with optional cycle timeout
module wait_any_arbiter #(
    parameter int N  = 4,
    parameter int TW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    wait_any_arbiter_if.slave bus
);
    localparam int WW = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] cnt;
    logic [TW-1:0] elapsed;
    logic [TW-1:0] elapsed_inc;
    logic [WW-1:0] fire_idx;
    logic          any_cond;
    logic          expire;

    // Lowest set condition bit wins; result is 1-based so zero can mean "none".
    always_comb begin
        fire_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.cond[i]) begin
                fire_idx = WW'(i + 1);
            end
        end
    end

    assign any_cond    = |bus.cond;
    assign expire      = (cnt == TW'(1));
    assign elapsed_inc = (elapsed == '1) ? elapsed : elapsed + TW'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: abort beats a condition, a condition beats a timeout expiring on the same edge.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.arm) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.abort) begin
                    state_nxt = ST_IDLE;
                end else if (any_cond || expire) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Timeout/elapsed counters and the result registers, written only on the terminating edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            elapsed         <= '0;
            bus.which       <= '0;
            bus.timed_out   <= 1'b0;
            bus.wait_cycles <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.arm) begin
                        cnt     <= bus.timeout;
                        elapsed <= '0;
                    end
                end
                ST_WAIT: begin
                    if (!bus.abort) begin
                        elapsed <= elapsed_inc;
                        // A zero capture means wait forever, so the counter stays parked at zero.
                        if (cnt != '0) begin
                            cnt <= cnt - TW'(1);
                        end
                        if (any_cond) begin
                            bus.which       <= fire_idx;
                            bus.timed_out   <= 1'b0;
                            bus.wait_cycles <= elapsed_inc;
                        end else if (expire) begin
                            bus.which       <= '0;
                            bus.timed_out   <= 1'b1;
                            bus.wait_cycles <= elapsed_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == ST_WAIT);
    assign bus.done = (state == ST_DONE);
endmodule
